// File: rtl/dot_product_accumulator_pkg.sv
// Shared constants and state encoding for the dot-product accumulator.
package dot_product_accumulator_pkg;

    localparam int unsigned DefLenW = 8;
    localparam int unsigned DefAccW = 40;
    localparam int unsigned ProdW   = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/sixteenbitarraymultiplier.sv
// Combinational 16x16 unsigned array multiplier: sum of shifted partial products.
module sixteenbitarraymultiplier (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] product
);

    always_comb begin
        product = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) begin
                product = product + ({16'b0, a} << i);
            end
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Streams operand pairs through a registered multiplier and sums len products.
module dot_product_accumulator
    import dot_product_accumulator_pkg::*;
#(
    parameter int unsigned LEN_W = DefLenW,
    parameter int unsigned ACC_W = DefAccW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               s1_valid_q, s1_valid_d;
    logic [15:0]        s1_a_q, s1_a_d;
    logic [15:0]        s1_b_q, s1_b_d;
    logic               s2_valid_q, s2_valid_d;
    logic [ProdW-1:0]   s2_prod_q, s2_prod_d;
    logic [ProdW-1:0]   mult_prod;
    logic [ACC_W:0]     sum;
    logic               accept;

    sixteenbitarraymultiplier u_mult (
        .a       (s1_a_q),
        .b       (s1_b_q),
        .product (mult_prod)
    );

    assign accept = in_valid && (state_q == StRun);
    // Extra top bit captures the carry out of the accumulator.
    assign sum    = {1'b0, acc_q} + (ACC_W + 1)'(s2_prod_q);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        s1_valid_d = accept;
        s1_a_d     = accept ? a : s1_a_q;
        s1_b_d     = accept ? b : s1_b_q;
        s2_valid_d = s1_valid_q;
        s2_prod_d  = s1_valid_q ? mult_prod : s2_prod_q;

        if (s2_valid_q) begin
            acc_d = sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
                ovf_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    len_d   = len;
                    state_d = (len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
        end
    end

    assign in_ready  = (state_q == StRun);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator; a 32-bit-accumulator copy shares the stimulus.
module tb_dot_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, overflow, busy;
    logic [39:0] result;
    logic        in_ready32, out_valid32, overflow32, busy32;
    logic [31:0] result32;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dot_product_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy)
    );

    dot_product_accumulator #(.LEN_W(8), .ACC_W(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .a         (a),
        .b         (b),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .result    (result32),
        .overflow  (overflow32),
        .busy      (busy32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] va, input logic [15:0] vb);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [39:0] held;

    initial begin
        // Reset with start and in_valid asserted
        start    = 1'b1;
        in_valid = 1'b1;
        len      = 8'd3;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        in_valid = 1'b0;

        // Single pair, 3-cycle latency
        start_job(8'd1);
        check("single_in_ready", 64'(in_ready), 64'd1);
        feed(16'd3, 16'd4);
        check("single_drain_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        check("single_lat2", 64'(out_valid), 64'd0);
        tick();
        check("single_lat3", 64'(out_valid), 64'd1);
        check("single_result", 64'(result), 64'd12);
        check("single_ovf", 64'(overflow), 64'd0);
        take_result();
        check("single_idle", 64'(busy), 64'd0);

        // Three pairs with idle gaps
        start_job(8'd3);
        feed(16'd3, 16'd4);
        tick();
        feed(16'd44, 16'd7258);
        tick();
        feed(16'd345, 16'd83);
        tick();
        tick();
        check("gap_lat2", 64'(out_valid), 64'd0);
        tick();
        check("gap_lat3", 64'(out_valid), 64'd1);
        check("gap_result", 64'(result), 64'd347999);
        take_result();

        // 255 full-scale pairs back to back
        start_job(8'd255);
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        in_valid = 1'b0;
        check("max_drain_ready", 64'(in_ready), 64'd0);
        wait_done("max_timeout", 10);
        check("max_result", 64'(result), 64'd1095183237375);
        check("max_ovf", 64'(overflow), 64'd0);
        take_result();

        // Two full-scale pairs: wraps the 32-bit accumulator only
        start_job(8'd2);
        feed(16'hFFFF, 16'hFFFF);
        feed(16'hFFFF, 16'hFFFF);
        wait_done("acc32_timeout", 10);
        check("acc32_valid", 64'(out_valid32), 64'd1);
        check("acc32_result", 64'(result32), 64'd4294705154);
        check("acc32_ovf", 64'(overflow32), 64'd1);
        check("acc40_result", 64'(result), 64'd8589672450);
        check("acc40_ovf", 64'(overflow), 64'd0);
        take_result();

        // Zero-length job; also clears sticky overflow
        start_job(8'd0);
        check("len0_valid", 64'(out_valid), 64'd1);
        check("len0_result", 64'(result), 64'd0);
        check("len0_ovf32", 64'(overflow32), 64'd0);
        check("len0_result32", 64'(result32), 64'd0);
        take_result();

        // Hold in DONE with out_ready low; start and in_valid ignored
        start_job(8'd1);
        feed(16'd100, 16'd200);
        wait_done("hold_timeout", 10);
        held     = result;
        start    = 1'b1;
        len      = 8'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_result", 64'(result), 64'd20000);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        check("hold_held", 64'(held), 64'd20000);
        in_valid = 1'b0;
        // start in the same cycle as the handshake is ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("accept_start_ignored", 64'(busy), 64'd0);
        tick();
        check("still_idle", 64'(busy), 64'd0);

        // Abort mid-run, then a clean job
        start_job(8'd4);
        feed(16'd1000, 16'd1000);
        feed(16'd2000, 16'd2000);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_job(8'd1);
        feed(16'd145, 16'd853);
        wait_done("abort_timeout", 10);
        check("abort_new_result", 64'(result), 64'd123685);
        check("abort_new_ovf", 64'(overflow), 64'd0);
        take_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
